// File: rtl/sqrt_sched_pkg.sv
// Shared types and defaults for the round-robin square-root scheduler.
package sqrt_sched_pkg;

  localparam int DIN_W_DEF   = 32;
  localparam int DOUT_W_DEF  = 17;
  localparam int LATENCY_DEF = 16;
  // Widest requester ID (N_REQ up to 8); narrower configurations use the low bits.
  localparam int ID_W_MAX    = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sqrt_rr_sched_rr_arb.sv
// Round-robin arbiter: searches upward from the last granted channel, wrapping around.
module rr_arb
  import sqrt_sched_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Priority search after the pointer and pointer update on an accepted grant.
  always_comb begin
    any       = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= N; off++) begin
      cand     = (int'(ptr_q) + off) % N;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any       = 1'b1;
        grant_idx = cand_idx;
      end else begin
        any = any;
      end
    end
    grant_oh = '0;
    if (any) begin
      grant_oh[grant_idx] = 1'b1;
    end else begin
      grant_oh = '0;
    end
    if (advance && any) begin
      ptr_d = grant_idx;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset value N-1 gives channel 0 first priority.
  always_ff @(posedge clk) begin
    if (sclr) begin
      ptr_q <= IDX_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sqrt_rr_sched.sv
// Shares one pipelined sqrt core among N_REQ requesters; IDs ride a tag pipe beside the core.
module sqrt_rr_sched
  import sqrt_sched_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DIN_W   = DIN_W_DEF,
  parameter  int DOUT_W  = DOUT_W_DEF,
  parameter  int LATENCY = LATENCY_DEF,
  localparam int ID_W    = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   sclr,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DIN_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [DIN_W-1:0]       core_x,
  output logic                   core_ce,
  output logic                   core_sclr,
  input  logic [DOUT_W-1:0]      core_x_out,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [DOUT_W-1:0]      res_data,
  input  logic                   res_ready,
  output logic                   busy
);

  if (LATENCY < 1) begin : g_latency_check
    $error("sqrt_rr_sched: LATENCY must be at least 1");
  end

  tag_t             tag_q [LATENCY];
  tag_t             tag_d [LATENCY];
  logic [N_REQ-1:0] grant_oh;
  logic [ID_W-1:0]  grant_idx;
  logic             any;
  logic             advance;
  logic             issue;

  rr_arb #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .sclr      (sclr),
    .req       (req_valid),
    .advance   (advance),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Stall when a real result waits at the tail; a bubble at the tail never blocks.
  always_comb begin
    core_sclr = sclr;
    core_ce   = ~(tag_q[LATENCY-1].valid & ~res_ready);
    advance   = core_ce & ~sclr;
    issue     = advance & any;
    if (advance) begin
      req_ready = grant_oh;
    end else begin
      req_ready = '0;
    end
    core_x = '0;
    if (issue) begin
      core_x = req_data[int'(grant_idx)*DIN_W +: DIN_W];
    end else begin
      core_x = '0;
    end
  end

  // Tag pipeline shifts in lock step with the core.
  always_comb begin
    tag_d = tag_q;
    if (core_ce) begin
      tag_d[0].valid = issue;
      tag_d[0].id    = ID_W_MAX'(grant_idx);
      for (int i = 1; i < LATENCY; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end else begin
      tag_d = tag_q;
    end
  end

  // Tag registers; reset discards every in-flight token.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q <= tag_d;
    end
  end

  // Result port and in-flight indication.
  always_comb begin
    res_valid = tag_q[LATENCY-1].valid;
    res_id    = tag_q[LATENCY-1].id[ID_W-1:0];
    res_data  = core_x_out;
    busy      = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

endmodule

// File: doc/sqrt_rr_sched.md
Name: sqrt_rr_sched

Overview:
- Shares one pipelined integer square-root core among N_REQ requesters.
- Per cycle: round-robin arbitration, issue of the granted operand into the core, and tracking of the requester ID alongside the core pipeline.
- Each result is returned with its ID on a single valid/ready output.
- The core is instantiated by the parent. This block only drives the core's operand, ce and sclr, and reads its output.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DIN_W, 32: operand width.
- DOUT_W, 17: result width.
- LATENCY, 16: core pipeline depth in ce-enabled clock edges. Must be ≥1; elaboration error otherwise.

Ports:
- clk  in  1  clock.
- sclr  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  per-channel request valid.
- req_data  in  N_REQ*DIN_W  operands, packed; channel i at [i*DIN_W +: DIN_W].
- req_ready  out  N_REQ  one-hot grant/accept.
- core_x  out  DIN_W  operand to core.
- core_ce  out  1  core clock enable.
- core_sclr  out  1  core reset.
- core_x_out  in  DOUT_W  core result (unsigned floor sqrt).
- res_valid  out  1  result valid.
- res_id  out  $clog2(N_REQ)  originating channel.
- res_data  out  DOUT_W  result.
- res_ready  in  1  downstream accept.
- busy  out  1  any token in flight.

Behaviour:
- One clock, clk. Reset is sclr: synchronous, active-high.
- **Reset:**
  - core_sclr = sclr, passed through combinationally.
  - On sclr, all tag-pipeline valids clear.
  - RR pointer resets to N_REQ-1, so channel 0 has first priority.
  - While sclr is high, req_ready = 0.
  - After reset: res_valid = 0 and busy = 0.
- **Tag pipeline:**
  - LATENCY stages of {valid, id}. All stages shift together only when core_ce = 1.
  - Stage 0 loads {issue, grant_idx}. A bubble (valid=0) enters when no channel is issued.
  - The tail stage is aligned with core_x_out.
- **Stall:**
  - stall = tail.valid & ~res_ready; core_ce = ~stall.
  - A bubble at the tail never stalls.
  - During stall the core and tags freeze, res_data/res_id hold stable, and req_ready = 0.
- **Issue:**
  - When core_ce = 1, the arbiter picks the first asserted req_valid after the RR pointer, wrapping around.
  - req_ready[grant] = 1 (combinational from req_valid; requesters must not make req_valid depend on req_ready).
  - core_x = req_data[grant]. When nothing is granted, core_x = 0.
  - The transfer completes on that edge.
  - The RR pointer updates to grant_idx only on an actual issue.
- **Output:** res_valid = tail.valid; res_id = tail.id; res_data = core_x_out. Transfer occurs on res_valid & res_ready.
- **Latency and throughput:** a request accepted at edge k gives res_valid in the cycle after edge k+LATENCY-1, i.e. LATENCY cycles later, when there are no stalls. Throughput is 1 result/cycle. Results leave in issue order.
- **Simultaneous events:** result drain and new issue in the same cycle are legal, with no bubble lost.
- **busy:** OR of all tag valids.
- **Mid-flight sclr:** all in-flight tokens are discarded. No res_valid appears for them afterwards.

Decomposition:
- Package sqrt_sched_pkg holds:
  - DIN_W/DOUT_W/LATENCY defaults;
  - the tag typedef {logic valid; logic [ID_W-1:0] id};
  - function clog2.
- Sub-module rr_arb:
  - parameter N;
  - inputs req[N], advance;
  - outputs grant_oh[N], grant_idx, any.
  - It owns the pointer, which is reset by sclr.

Test Plan (LATENCY=16, N_REQ=4):
1. **Single request:** ch2 x=144 accepted at cycle 10 → req_ready[2] high exactly 1 cycle; res_valid at cycle 26, res_id=2, res_data=12; busy 0 afterwards.
2. **All channels saturated:** all 4 channels valid continuously with x = 0, 1, 65536, 0xFFFFFFFF → grants 0,1,2,3,0,...; results in that order with data 0, 1, 256, 65535 and IDs 0..3; one result per cycle.
3. **Backpressure:** res_ready low 5 cycles while tail valid → core_ce low exactly 5 cycles, res_data/res_id stable, req_ready all 0; no results lost or duplicated.
4. **Bubbles:** requests on alternate cycles with res_ready = 0 whenever tail is a bubble → no stall (core_ce stays 1); res_valid alternates.
5. **Reset mid-flight:** sclr asserted with 8 tokens in flight → res_valid stays 0 for the next 40 cycles. Then ch0 and ch3 request together → ch0 granted first, ch3 next.
6. **Fairness:** ch1 held valid continuously and ch3 asserts → ch3 granted within N_REQ cycles; grants alternate 1,3,1,3.
